// File: rtl/regfile_arb_pkg.sv
// Shared types and constants for the register-file write-port arbiter.
// Holds the reserved register numbers, the FIFO entry layout and the grant-source encoding.
package regfile_arb_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int REG_DATA_W = 32;

    localparam logic [REG_ADDR_W-1:0] REG_ZERO = 5'd0;
    localparam logic [REG_ADDR_W-1:0] REG_RAND = 5'd29;

    typedef struct packed {
        logic [REG_ADDR_W-1:0] wr_reg;
        logic [REG_DATA_W-1:0] wr_data;
    } wr_req_t;

    typedef enum logic [1:0] {
        GNT_NONE,
        GNT_CPU,
        GNT_IO,
        GNT_IO_FORCED
    } grant_src_e;

    // r0 reads as constant zero and r29 is hardwired to random_data, so writes to them are dropped
    function automatic logic is_reserved_reg(input logic [REG_ADDR_W-1:0] r);
        return (r == REG_ZERO) || (r == REG_RAND);
    endfunction

endpackage

// File: rtl/regfile_wr_fifo.sv
// Synchronous FIFO buffering I/O write requests for the register-file arbiter.
// Exposes full/empty/count; pointers and occupancy reset asynchronously.
module regfile_wr_fifo
    import regfile_arb_pkg::*;
#(
    parameter int DEPTH = 4,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clock,
    input  logic             ctrl_reset,
    input  logic             push,
    input  wr_req_t          push_req,
    input  logic             pop,
    output wr_req_t          head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    wr_req_t          mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [CNT_W-1:0] count_q;
    logic             do_push;
    logic             do_pop;

    assign full    = (count_q == CNT_W'(DEPTH));
    assign empty   = (count_q == '0);
    assign count   = count_q;
    assign head    = mem[rd_ptr];
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    // Storage carries no reset; only the pointers decide what is valid
    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= push_req;
        end
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count_q <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/regfile_write_arbiter.sv
// Shares the regfile write port between writeback (priority) and buffered game I/O writes.
// Optional event counters are built only when REGFILE_ARB_STATS_EN is defined.
module regfile_write_arbiter
    import regfile_arb_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int MAX_WAIT   = 8,
    localparam int CNT_W     = $clog2(FIFO_DEPTH) + 1
) (
    input  logic                  clock,
    input  logic                  ctrl_reset,
    input  logic                  cpu_we,
    input  logic [REG_ADDR_W-1:0] cpu_wr_reg,
    input  logic [REG_DATA_W-1:0] cpu_wr_data,
    input  logic                  io_valid,
    input  logic [REG_ADDR_W-1:0] io_reg,
    input  logic [REG_DATA_W-1:0] io_data,
    output logic                  io_ready,
    output logic                  cpu_stall,
    output logic                  ctrl_writeEnable,
    output logic [REG_ADDR_W-1:0] ctrl_writeReg,
    output logic [REG_DATA_W-1:0] data_writeReg,
    output logic [CNT_W-1:0]      fifo_count,
    output logic [15:0]           io_commits,
    output logic [15:0]           stall_cycles
);

    localparam logic [7:0] WAIT_LIMIT = 8'(MAX_WAIT);

    wr_req_t    push_req;
    wr_req_t    fifo_head;
    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_push;
    logic       fifo_pop;
    logic [7:0] wait_cnt;
    grant_src_e grant;

    assign io_ready  = !fifo_full;
    assign push_req  = '{wr_reg: io_reg, wr_data: io_data};
    assign fifo_push = io_valid && io_ready && !is_reserved_reg(io_reg);

    regfile_wr_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clock      (clock),
        .ctrl_reset (ctrl_reset),
        .push       (fifo_push),
        .push_req   (push_req),
        .pop        (fifo_pop),
        .head       (fifo_head),
        .full       (fifo_full),
        .empty      (fifo_empty),
        .count      (fifo_count)
    );

    // Starvation guard beats the processor; otherwise writeback has priority
    always_comb begin
        grant = GNT_NONE;
        if (!fifo_empty && (wait_cnt == WAIT_LIMIT)) begin
            grant = GNT_IO_FORCED;
        end else if (cpu_we) begin
            grant = GNT_CPU;
        end else if (!fifo_empty) begin
            grant = GNT_IO;
        end
    end

    always_comb begin
        ctrl_writeEnable = 1'b0;
        ctrl_writeReg    = '0;
        data_writeReg    = '0;
        fifo_pop         = 1'b0;
        cpu_stall        = 1'b0;
        case (grant)
            GNT_CPU: begin
                ctrl_writeEnable = !is_reserved_reg(cpu_wr_reg);
                ctrl_writeReg    = cpu_wr_reg;
                data_writeReg    = cpu_wr_data;
            end
            GNT_IO, GNT_IO_FORCED: begin
                ctrl_writeEnable = !is_reserved_reg(fifo_head.wr_reg);
                ctrl_writeReg    = fifo_head.wr_reg;
                data_writeReg    = fifo_head.wr_data;
                fifo_pop         = 1'b1;
                cpu_stall        = (grant == GNT_IO_FORCED) && cpu_we;
            end
            default: begin
                ctrl_writeEnable = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            wait_cnt <= '0;
        end else if (fifo_empty || fifo_pop) begin
            wait_cnt <= '0;
        end else if ((grant == GNT_CPU) && (wait_cnt != WAIT_LIMIT)) begin
            wait_cnt <= wait_cnt + 8'd1;
        end
    end

`ifdef REGFILE_ARB_STATS_EN
    logic [15:0] io_commits_q;
    logic [15:0] stall_cycles_q;

    // Both counters saturate and clear only on reset
    always_ff @(posedge clock or posedge ctrl_reset) begin
        if (ctrl_reset) begin
            io_commits_q   <= '0;
            stall_cycles_q <= '0;
        end else begin
            if (fifo_pop && !is_reserved_reg(fifo_head.wr_reg) && (io_commits_q != 16'hFFFF)) begin
                io_commits_q <= io_commits_q + 16'd1;
            end
            if (cpu_stall && (stall_cycles_q != 16'hFFFF)) begin
                stall_cycles_q <= stall_cycles_q + 16'd1;
            end
        end
    end

    assign io_commits   = io_commits_q;
    assign stall_cycles = stall_cycles_q;
`else
    assign io_commits   = 16'd0;
    assign stall_cycles = 16'd0;
`endif

endmodule
